// File: rtl/seq1101_stream_scheduler.sv
// rtl/seq1101_stream_scheduler.sv - round-robin time-sharing of one external 1101 finder across N_CH bit streams
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_valid/in_bit/in_ready       per-stream serial bit offer and one-hot grant (grant is combinational)
//   chan_clr                       per-stream synchronous clear of finder state and hit counter
//   fsm_c0/fsm_c1/fsm_in           granted stream's stored state and bit, driven to the finder
//   fsm_next0/fsm_next1/fsm_out    finder's next state and same-cycle detect for the granted stream
//   det_valid/det_ch               registered detection pulse and its channel
//   cnt_sel/cnt_val                combinational readback of one channel's saturating hit counter
module seq1101_stream_scheduler #(
    parameter int N_CH  = 4,
    parameter int CH_W  = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_CH-1:0]  in_valid,
    input  logic [N_CH-1:0]  in_bit,
    output logic [N_CH-1:0]  in_ready,
    input  logic [N_CH-1:0]  chan_clr,
    output logic             fsm_c0,
    output logic             fsm_c1,
    output logic             fsm_in,
    input  logic             fsm_next0,
    input  logic             fsm_next1,
    input  logic             fsm_out,
    output logic             det_valid,
    output logic [CH_W-1:0]  det_ch,
    input  logic [CH_W-1:0]  cnt_sel,
    output logic [CNT_W-1:0] cnt_val
);

    logic [1:0]       state_q [N_CH];
    logic [1:0]       state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             det_valid_q, det_valid_d;
    logic [CH_W-1:0]  det_ch_q, det_ch_d;

    logic [N_CH-1:0]  elig;
    logic             grant_vld;
    logic [CH_W-1:0]  grant_idx;
    logic [CH_W:0]    idx_w;

    // Round-robin search starting at rr_ptr. Gating with rst_n keeps the
    // grant (and therefore the finder drive) quiet while reset is held.
    // A cleared stream is never eligible, so the clear always wins.
    always_comb begin
        elig      = in_valid & ~chan_clr & {N_CH{rst_n}};
        grant_vld = 1'b0;
        grant_idx = '0;
        idx_w     = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx_w = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
            if (idx_w >= (CH_W+1)'(N_CH)) begin
                idx_w = idx_w - (CH_W+1)'(N_CH);
            end
            if (!grant_vld && elig[idx_w[CH_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = idx_w[CH_W-1:0];
            end
        end
    end

    // Next-state: clears first, then the granted stream's write-back.
    // A granted stream is never being cleared in the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;
        for (int k = 0; k < N_CH; k++) begin
            if (chan_clr[k]) begin
                state_d[k] = 2'b00;
                cnt_d[k]   = '0;
            end
        end
        if (grant_vld) begin
            state_d[grant_idx] = {fsm_next1, fsm_next0};
            det_valid_d        = fsm_out;
            det_ch_d           = grant_idx;
            rr_ptr_d           = (grant_idx == CH_W'(N_CH-1)) ? '0 : grant_idx + CH_W'(1);
            if (fsm_out && (cnt_q[grant_idx] != {CNT_W{1'b1}})) begin
                cnt_d[grant_idx] = cnt_q[grant_idx] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                state_q[k] <= 2'b00;
                cnt_q[k]   <= '0;
            end
            rr_ptr_q    <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
        end
    end

    // Output drive: the finder only sees the granted stream; idle drives zeros.
    always_comb begin
        in_ready = '0;
        fsm_c0   = 1'b0;
        fsm_c1   = 1'b0;
        fsm_in   = 1'b0;
        if (grant_vld) begin
            in_ready[grant_idx] = 1'b1;
            {fsm_c1, fsm_c0}    = state_q[grant_idx];
            fsm_in              = in_bit[grant_idx];
        end
    end

    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;
    assign cnt_val   = cnt_q[cnt_sel];

endmodule

// File: tb/tb_seq1101_stream_scheduler.sv
// tb/tb_seq1101_stream_scheduler.sv - randomized and directed self-checking bench for seq1101_stream_scheduler
module tb_seq1101_stream_scheduler;

    localparam int N_CH  = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N_CH-1:0]  in_valid = '0;
    logic [N_CH-1:0]  in_bit = '0;
    logic [N_CH-1:0]  in_ready;
    logic [N_CH-1:0]  chan_clr = '0;
    logic             fsm_c0, fsm_c1, fsm_in;
    logic             fsm_next0, fsm_next1, fsm_out;
    logic             det_valid;
    logic [CH_W-1:0]  det_ch;
    logic [CH_W-1:0]  cnt_sel = '0;
    logic [CNT_W-1:0] cnt_val;

    seq1101_stream_scheduler #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .chan_clr(chan_clr),
        .fsm_c0(fsm_c0), .fsm_c1(fsm_c1), .fsm_in(fsm_in),
        .fsm_next0(fsm_next0), .fsm_next1(fsm_next1), .fsm_out(fsm_out),
        .det_valid(det_valid), .det_ch(det_ch), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
    );

    always #5 clk = ~clk;

    // External 1101 finder: 0 idle, 1 "1", 2 "11", 3 "110"; overlapping, Mealy.
    always_comb begin
        fsm_next0 = 1'b0;
        fsm_next1 = 1'b0;
        fsm_out   = 1'b0;
        case ({fsm_c1, fsm_c0})
            2'd0:    {fsm_next1, fsm_next0} = fsm_in ? 2'd1 : 2'd0;
            2'd1:    {fsm_next1, fsm_next0} = fsm_in ? 2'd2 : 2'd0;
            2'd2:    {fsm_next1, fsm_next0} = fsm_in ? 2'd2 : 2'd3;
            default: begin
                {fsm_next1, fsm_next0} = fsm_in ? 2'd1 : 2'd0;
                fsm_out = fsm_in;
            end
        endcase
    end

    // Reference model: per-stream history of the last four accepted bits.
    logic [3:0] m_hist [N_CH];
    int         m_len  [N_CH];
    int         m_cnt  [N_CH];
    int         m_rr;
    int         m_det;
    int         m_det_ch;
    int         obs_hits [N_CH];
    int         last_grant;
    int         n_cmp = 0;
    int         n_bad = 0;

    logic [15:0] p_bits [N_CH];
    int          p_len  [N_CH];
    int          p_idx  [N_CH];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_hist[k] = '0;
            m_len[k]  = 0;
            m_cnt[k]  = 0;
        end
        m_rr     = 0;
        m_det    = 0;
        m_det_ch = 0;
    endtask

    task automatic clear_obs();
        for (int k = 0; k < N_CH; k++) obs_hits[k] = 0;
    endtask

    // Finder state implied by the bit history: longest suffix that is a prefix of 1101.
    function automatic int exp_state(input int k);
        if (m_len[k] >= 3 && m_hist[k][2:0] == 3'b110) return 3;
        if (m_len[k] >= 2 && m_hist[k][1:0] == 2'b11) return 2;
        if (m_len[k] >= 1 && m_hist[k][0]) return 1;
        return 0;
    endfunction

    function automatic int model_grant();
        for (int i = 0; i < N_CH; i++) begin
            int k;
            k = (m_rr + i) % N_CH;
            if (rst_n && in_valid[k] && !chan_clr[k]) return k;
        end
        return -1;
    endfunction

    // Called just after a falling edge with inputs already set.
    task automatic cycle();
        int g;
        #1;
        g = model_grant();
        chk("in_ready", int'(in_ready), (g >= 0) ? (1 << g) : 0);
        chk("fsm_in", int'(fsm_in), (g >= 0) ? int'(in_bit[g]) : 0);
        chk("fsm_state", int'({fsm_c1, fsm_c0}), (g >= 0) ? exp_state(g) : 0);
        chk("det_valid", int'(det_valid), m_det);
        chk("det_ch", int'(det_ch), m_det_ch);
        chk("cnt_val", int'(cnt_val), m_cnt[cnt_sel]);
        if (det_valid) obs_hits[det_ch]++;
        last_grant = g;
        @(posedge clk);
        if (rst_n) begin
            if (g >= 0) begin
                m_hist[g] = {m_hist[g][2:0], in_bit[g]};
                if (m_len[g] < 4) m_len[g]++;
                m_det    = (m_len[g] >= 4 && m_hist[g] == 4'b1101) ? 1 : 0;
                m_det_ch = g;
                if (m_det == 1 && m_cnt[g] < CMAX) m_cnt[g]++;
                m_rr = (g + 1) % N_CH;
            end else begin
                m_det = 0;
            end
            for (int k = 0; k < N_CH; k++) begin
                if (chan_clr[k]) begin
                    m_hist[k] = '0;
                    m_len[k]  = 0;
                    m_cnt[k]  = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic peek_cnt(input string name, input int ch, input int exp);
        cnt_sel = CH_W'(ch);
        #1;
        chk(name, int'(cnt_val), exp);
    endtask

    // Asynchronous reset asserted and released away from the rising edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_det_valid", int'(det_valid), 0);
        model_reset();
        clear_obs();
        cycle();
        rst_n    = 1'b1;
        in_valid = '0;
        chan_clr = '0;
    endtask

    task automatic set_pat(input int k, input string s);
        p_bits[k] = '0;
        p_len[k]  = s.len();
        p_idx[k]  = 0;
        for (int i = 0; i < s.len(); i++) p_bits[k][i] = (s[i] == "1");
    endtask

    task automatic clr_pats();
        for (int k = 0; k < N_CH; k++) begin
            p_len[k] = 0;
            p_idx[k] = 0;
        end
    endtask

    // Plays all loaded patterns, each producer holding its bit until granted.
    task automatic run_pats();
        int budget;
        bit busy;
        budget = 200;
        busy   = 1'b1;
        while (busy && budget > 0) begin
            busy = 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                in_valid[k] = (p_idx[k] < p_len[k]);
                in_bit[k]   = (p_idx[k] < p_len[k]) ? p_bits[k][p_idx[k]] : 1'b0;
                if (p_idx[k] < p_len[k]) busy = 1'b1;
            end
            if (busy) begin
                cycle();
                if (last_grant >= 0) p_idx[last_grant]++;
                budget--;
            end
        end
        if (busy) chk("pattern_timeout", 1, 0);
        in_valid = '0;
        cycle();
    endtask

    initial begin
        model_reset();
        clear_obs();
        clr_pats();
        @(negedge clk);

        // 1: reset held with every stream offering
        in_valid = 4'b1111;
        for (int s = 0; s < N_CH; s++) peek_cnt("t1_cnt_reset", s, 0);
        cycle();
        chk("t1_in_ready", int'(in_ready), 0);
        rst_n    = 1'b1;
        in_valid = '0;

        // 2: single stream ch2 sends 1101
        clr_pats();
        set_pat(2, "1101");
        run_pats();
        chk("t2_hits_ch2", obs_hits[2], 1);
        peek_cnt("t2_cnt2", 2, 1);

        // 3: round robin with all streams offering
        do_reset();
        for (int i = 0; i < 9; i++) begin
            in_valid = 4'b1111;
            in_bit   = 4'($urandom_range(0, 15));
            #1 chk("t3_grant", int'(in_ready), 1 << (i % 4));
            cycle();
        end
        in_valid = 4'b1010;
        #1 chk("t3_grant_1010", int'(in_ready), 4'b0010);
        cycle();
        in_valid = '0;

        // 4: two interleaved streams, overlapping detections
        do_reset();
        clr_pats();
        set_pat(0, "1101101");
        set_pat(3, "1101101");
        run_pats();
        chk("t4_hits_ch0", obs_hits[0], 2);
        chk("t4_hits_ch3", obs_hits[3], 2);
        peek_cnt("t4_cnt0", 0, 2);
        peek_cnt("t4_cnt3", 3, 2);
        peek_cnt("t4_cnt1", 1, 0);
        peek_cnt("t4_cnt2", 2, 0);

        // 5: clear collides with an offer on ch1
        do_reset();
        clr_pats();
        set_pat(1, "110");
        run_pats();
        in_valid = 4'b0110;
        in_bit   = 4'b0010;
        chan_clr = 4'b0010;
        #1 chk("t5_clear_grant", int'(in_ready), 4'b0100);
        cycle();
        chan_clr = '0;
        in_valid = '0;
        clr_pats();
        set_pat(1, "1");
        run_pats();
        chk("t5_no_hit_after_clr", obs_hits[1], 0);
        clr_pats();
        set_pat(1, "1101");
        run_pats();
        chk("t5_hit_after_1101", obs_hits[1], 1);

        // 6: counter saturation, then reset in the middle of "110"
        do_reset();
        clr_pats();
        set_pat(0, "1101101101101101");
        run_pats();
        chk("t6_pulses", obs_hits[0], 5);
        peek_cnt("t6_cnt_sat", 0, CMAX);
        clr_pats();
        set_pat(0, "110");
        run_pats();
        do_reset();
        clr_pats();
        set_pat(0, "1");
        run_pats();
        chk("t6_no_hit_after_rst", obs_hits[0], 0);

        // Randomized traffic with occasional clears
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N_CH; k++) begin
                if (!in_valid[k] && $urandom_range(0, 9) < 6) begin
                    in_valid[k] = 1'b1;
                    in_bit[k]   = 1'($urandom_range(0, 1));
                end
            end
            chan_clr = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(0, 15)) : '0;
            cnt_sel  = CH_W'($urandom_range(0, N_CH - 1));
            cycle();
            if (last_grant >= 0) in_valid[last_grant] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
